// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: width codes, FSM states
// and the captured request record.
package dmem_pkg;

    localparam logic [2:0] WIDTH_32  = 3'b000;
    localparam logic [2:0] WIDTH_16S = 3'b010;
    localparam logic [2:0] WIDTH_16U = 3'b011;
    localparam logic [2:0] WIDTH_8S  = 3'b100;
    localparam logic [2:0] WIDTH_8U  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  width;
        logic        write;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_gen.sv
// Store lane steering: byte enables, replicated lane data and misalignment
// detection for one access. Misaligned accesses get no byte enables.
module dmem_lane_gen
    import dmem_pkg::*;
(
    input  logic [2:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_data,
    output logic        misaligned
);

    always_comb begin
        byte_en    = 4'b0000;
        lane_data  = wdata;
        misaligned = 1'b0;
        case (width)
            WIDTH_8S, WIDTH_8U: begin
                byte_en   = 4'b0001 << addr_lo;
                lane_data = {4{wdata[7:0]}};
            end
            WIDTH_16S, WIDTH_16U: begin
                misaligned = addr_lo[0];
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{wdata[15:0]}};
            end
            // Unknown codes fall through to word width.
            default: begin
                misaligned = (addr_lo != 2'b00);
                byte_en    = 4'b1111;
            end
        endcase
        if (misaligned) begin
            byte_en = 4'b0000;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one load/store, waits LATENCY busy cycles,
// performs the access on an internal word SRAM and reports completion.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter  int DEPTH     = 1024,
    parameter  int LATENCY   = 2,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        mem_req_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    input  logic [2:0]  width_src_i,
    output logic [31:0] read_data_o,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic        misaligned_o,
    output dmem_state_t state_o
);

    localparam logic [3:0] LAT_CNT = 4'(LATENCY - 1);

    dmem_state_t          state_q, state_d;
    logic [3:0]           cnt_q;
    dmem_req_t            req_q;
    logic [31:0]          rdata_q;
    logic                 mis_q;
    logic [31:0]          mem [DEPTH];
    logic [3:0]           byte_en;
    logic [31:0]          lane_data;
    logic                 lane_mis;
    logic                 complete;
    logic [ADDR_BITS-1:0] word_idx;

    dmem_lane_gen u_lane_gen (
        .width      (req_q.width),
        .addr_lo    (req_q.addr[1:0]),
        .wdata      (req_q.data),
        .byte_en    (byte_en),
        .lane_data  (lane_data),
        .misaligned (lane_mis)
    );

    assign word_idx    = req_q.addr[ADDR_BITS+1:2];
    assign complete    = (state_q == BUSY) && (cnt_q == 4'd0);
    assign read_data_o = rdata_q;
    assign state_o     = state_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stall_o is a hold, not a handshake: a request presented in IDLE is
    // accepted immediately and must be held stable until resp_valid_o.
    always_comb begin
        state_d      = state_q;
        stall_o      = 1'b0;
        resp_valid_o = 1'b0;
        misaligned_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    stall_o = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid_o = 1'b1;
                misaligned_o = mis_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!reset_ni) begin
            stall_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && mem_req_i) begin
                req_q.addr  <= addr_i;
                req_q.data  <= write_data_i;
                req_q.width <= width_src_i;
                req_q.write <= mem_write_i;
                cnt_q       <= LAT_CNT;
            end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (complete) begin
                mis_q <= lane_mis;
                if (!req_q.write) begin
                    rdata_q <= lane_mis ? 32'h0 : mem[word_idx];
                end
            end
        end
    end

    // Array is deliberately not reset; misaligned stores arrive with no enables.
    always_ff @(posedge clk_i) begin
        if (complete && req_q.write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= lane_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder against a byte-level
// reference model of the word memory.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LATENCY = 2;

    logic        clk_i        = 1'b0;
    logic        reset_ni     = 1'b0;
    logic        mem_req_i    = 1'b0;
    logic        mem_write_i  = 1'b0;
    logic [31:0] addr_i       = 32'h0;
    logic [31:0] write_data_i = 32'h0;
    logic [2:0]  width_src_i  = 3'b000;
    logic [31:0] read_data_o;
    logic        stall_o;
    logic        resp_valid_o;
    logic        misaligned_o;
    dmem_state_t state_o;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [1024];
    logic [31:0] last_rd = 32'h0;

    dmem_responder #(.DEPTH(1024), .LATENCY(LATENCY)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .mem_req_i    (mem_req_i),
        .mem_write_i  (mem_write_i),
        .addr_i       (addr_i),
        .write_data_i (write_data_i),
        .width_src_i  (width_src_i),
        .read_data_o  (read_data_o),
        .stall_o      (stall_o),
        .resp_valid_o (resp_valid_o),
        .misaligned_o (misaligned_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int width_bytes(input logic [2:0] w);
        if (w == WIDTH_8S || w == WIDTH_8U) return 1;
        if (w == WIDTH_16S || w == WIDTH_16U) return 2;
        return 4;
    endfunction

    function automatic logic model_mis(input logic [2:0] w, input logic [31:0] a);
        int nb;
        nb = width_bytes(w);
        return (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] a,
                                                input logic [31:0] d, input logic [2:0] w);
        logic [31:0] r;
        int nb, base;
        r    = old;
        nb   = width_bytes(w);
        base = (nb == 4) ? 0 : int'(a[1:0]);
        for (int k = 0; k < nb; k++) r[(base + k)*8 +: 8] = d[k*8 +: 8];
        return r;
    endfunction

    task automatic do_op(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] w, output logic [31:0] rd, output logic mis);
        int          stalls, idx;
        bit          got;
        logic        mis_exp;
        logic [31:0] rd_exp;
        idx     = int'(addr[11:2]);
        mis_exp = model_mis(w, addr);
        rd_exp  = wr ? last_rd : (mis_exp ? 32'h0 : model_mem[idx]);
        @(negedge clk_i);
        mem_req_i    = 1'b1;
        mem_write_i  = wr;
        addr_i       = addr;
        write_data_i = data;
        width_src_i  = w;
        stalls = 0;
        got    = 1'b0;
        rd     = 32'h0;
        mis    = 1'b0;
        #1;
        for (int c = 0; c < 50; c++) begin
            if (resp_valid_o) begin
                got = 1'b1;
                break;
            end
            if (stall_o) stalls++;
            @(negedge clk_i);
        end
        check("resp_seen", 32'(got), 32'd1);
        check("stall_cycles", stalls, LATENCY + 1);
        check("stall_in_done", 32'(stall_o), 32'd0);
        check("misaligned", 32'(misaligned_o), 32'(mis_exp));
        check(wr ? "rdata_after_store" : "rdata_load", read_data_o, rd_exp);
        rd  = read_data_o;
        mis = misaligned_o;
        mem_req_i = 1'b0;
        if (wr && !mis_exp) model_mem[idx] = model_merge(model_mem[idx], addr, data, w);
        if (!wr) last_rd = rd_exp;
        @(negedge clk_i);
        check("resp_one_cycle", 32'(resp_valid_o), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        mis;
        logic [2:0]  wl [8];
        logic        wr;
        logic [31:0] a;
        wl = '{WIDTH_32, WIDTH_16S, WIDTH_16U, WIDTH_8S, WIDTH_8U, 3'b001, 3'b110, 3'b111};

        // Reset state.
        repeat (2) @(negedge clk_i);
        check("rst_rdata", read_data_o, 32'h0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_resp", 32'(resp_valid_o), 32'd0);
        check("rst_mis", 32'(misaligned_o), 32'd0);
        check("rst_state", 32'(state_o), 32'(IDLE));
        reset_ni = 1'b1;

        // Word store then load.
        do_op(1'b1, 32'h10, 32'hDEADBEEF, WIDTH_32, rd, mis);
        do_op(1'b0, 32'h10, 32'h0, WIDTH_32, rd, mis);
        check("word_load", rd, 32'hDEADBEEF);

        // Byte store into an existing word.
        do_op(1'b1, 32'h10, 32'h11223344, WIDTH_32, rd, mis);
        do_op(1'b1, 32'h13, 32'hFFFFFFA5, WIDTH_8U, rd, mis);
        do_op(1'b0, 32'h10, 32'h0, WIDTH_32, rd, mis);
        check("byte_store", rd, 32'hA5223344);

        // Half store on upper half.
        do_op(1'b1, 32'h14, 32'h00000000, WIDTH_32, rd, mis);
        do_op(1'b1, 32'h16, 32'h1234BEEF, WIDTH_16S, rd, mis);
        do_op(1'b0, 32'h14, 32'h0, WIDTH_32, rd, mis);
        check("half_store", rd, 32'hBEEF0000);

        // Misaligned store suppressed, misaligned load returns zero.
        do_op(1'b1, 32'h20, 32'h55AA55AA, WIDTH_32, rd, mis);
        do_op(1'b1, 32'h21, 32'h99999999, WIDTH_32, rd, mis);
        check("mis_word_store_flag", 32'(mis), 32'd1);
        do_op(1'b0, 32'h20, 32'h0, WIDTH_32, rd, mis);
        check("mis_store_suppressed", rd, 32'h55AA55AA);
        do_op(1'b0, 32'h33, 32'h0, WIDTH_16U, rd, mis);
        check("mis_half_load_flag", 32'(mis), 32'd1);
        check("mis_half_load_data", rd, 32'h0);

        // Address wrap modulo DEPTH words.
        do_op(1'b1, 32'h1000, 32'h12345678, WIDTH_32, rd, mis);
        do_op(1'b0, 32'h0000, 32'h0, WIDTH_32, rd, mis);
        check("addr_wrap", rd, 32'h12345678);

        // Reset in the middle of a store.
        do_op(1'b1, 32'h40, 32'hCAFEF00D, WIDTH_32, rd, mis);
        do_op(1'b0, 32'h10, 32'h0, WIDTH_32, rd, mis);
        @(negedge clk_i);
        mem_req_i    = 1'b1;
        mem_write_i  = 1'b1;
        addr_i       = 32'h40;
        write_data_i = 32'h0BADBEEF;
        width_src_i  = WIDTH_32;
        @(posedge clk_i);
        #2;
        check("busy_before_reset", 32'(state_o), 32'(BUSY));
        reset_ni = 1'b0;
        #1;
        check("async_rst_stall", 32'(stall_o), 32'd0);
        check("async_rst_resp", 32'(resp_valid_o), 32'd0);
        check("async_rst_mis", 32'(misaligned_o), 32'd0);
        check("async_rst_rdata", read_data_o, 32'h0);
        check("async_rst_state", 32'(state_o), 32'(IDLE));
        mem_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        last_rd  = 32'h0;
        do_op(1'b0, 32'h40, 32'h0, WIDTH_32, rd, mis);
        check("inflight_store_dropped", rd, 32'hCAFEF00D);

        // Randomized traffic over a 16-word window, upper address bits scrambled.
        for (int i = 0; i < 16; i++) begin
            do_op(1'b1, 32'h100 + 32'(i * 4), $urandom, WIDTH_32, rd, mis);
        end
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = {20'($urandom), 12'h100 + 12'($urandom_range(0, 63))};
            do_op(wr, a, $urandom, wl[$urandom_range(0, 7)], rd, mis);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
